// File: rtl/axis_mux_pkg.sv
// Shared types and helpers for the packet-aware AXI-Stream multiplexer.
// The round-robin helper serves the AXIS_MUX_PKT_RR_ARB_EN build.
package axis_mux_pkg;

    localparam int MAX_CH = 16;

    typedef enum logic {
        IDLE,
        BUSY
    } mux_state_t;

    // Returns the first valid channel after 'last' (wrapping modulo n_ch);
    // bit 4 set means no channel is valid.
    function automatic logic [4:0] rr_next(input logic [MAX_CH-1:0] valid,
                                           input logic [3:0]        last,
                                           input int                n_ch);
        logic [4:0] grant;
        int         idx;
        grant = 5'(MAX_CH);
        // Walk from the farthest offset down so the nearest valid channel wins.
        for (int i = MAX_CH; i >= 1; i--) begin
            if (i <= n_ch) begin
                idx = int'(last) + i;
                if (idx >= n_ch) idx = idx - n_ch;
                if (valid[idx]) grant = 5'(idx);
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/axis_skid_slice.sv
// Two-entry AXI-Stream register slice carrying tdata+tlast at one beat/cycle;
// the upstream ready is a flop, so m_tready has no combinational path back.
module axis_skid_slice #(
    parameter int DATA_W = 32
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [DATA_W-1:0] s_tdata_i,
    input  logic              s_tlast_i,
    input  logic              s_tvalid_i,
    output logic              s_tready_o,
    output logic [DATA_W-1:0] m_tdata_o,
    output logic              m_tlast_o,
    output logic              m_tvalid_o,
    input  logic              m_tready_i
);

    logic [DATA_W:0] main_q, main_d, skid_q, skid_d;
    logic            main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
    logic            rdy_q;
    logic            pop, push;

    assign pop  = main_vld_q & m_tready_i;
    assign push = s_tvalid_i & rdy_q;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        main_d     = main_q;
        main_vld_d = main_vld_q;
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;
        if (skid_vld_q) begin
            if (pop) begin
                main_d     = skid_q;
                skid_vld_d = 1'b0;
            end
        end else if (push) begin
            if (!main_vld_q || pop) begin
                main_d     = {s_tlast_i, s_tdata_i};
                main_vld_d = 1'b1;
            end else begin
                skid_d     = {s_tlast_i, s_tdata_i};
                skid_vld_d = 1'b1;
            end
        end else if (pop) begin
            main_vld_d = 1'b0;
        end
    end

    // NOTE: the data registers are reset too, so m_tdata/m_tlast read 0 out of reset.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            main_q     <= '0;
            skid_q     <= '0;
            main_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
            rdy_q      <= 1'b0;
        end else begin
            main_q     <= main_d;
            skid_q     <= skid_d;
            main_vld_q <= main_vld_d;
            skid_vld_q <= skid_vld_d;
            rdy_q      <= ~skid_vld_d;
        end
    end

    assign s_tready_o = rdy_q;
    assign m_tvalid_o = main_vld_q;
    assign m_tlast_o  = main_q[DATA_W];
    assign m_tdata_o  = main_q[DATA_W-1:0];

endmodule

// File: rtl/axis_mux_pkt.sv
// N:1 AXI-Stream mux that only switches channel on packet boundaries.
// Define AXIS_MUX_PKT_RR_ARB_EN to replace Mux_Sel with round-robin arbitration.
module axis_mux_pkt
    import axis_mux_pkg::*;
#(
    parameter  int N_CH   = 4,
    parameter  int DATA_W = 32,
    localparam int SEL_W  = $clog2(N_CH)
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic [SEL_W-1:0]       Mux_Sel,
    input  logic [N_CH*DATA_W-1:0] s_tdata,
    input  logic [N_CH-1:0]        s_tvalid,
    input  logic [N_CH-1:0]        s_tlast,
    output logic [N_CH-1:0]        s_tready,
    output logic [DATA_W-1:0]      m_tdata,
    output logic                   m_tvalid,
    output logic                   m_tlast,
    input  logic                   m_tready,
    output logic                   busy,
    output logic [SEL_W-1:0]       cur_sel
);

    mux_state_t        state_q, state_d;
    logic [SEL_W-1:0]  cur_sel_q, cur_sel_d;
    logic [SEL_W-1:0]  grant;
    logic              grant_vld;
    logic              slice_ready, sel_valid, sel_last, accept;
    logic [DATA_W-1:0] sel_data;

`ifdef AXIS_MUX_PKT_RR_ARB_EN
    logic [SEL_W-1:0] last_grant_q, last_grant_d;
    logic [4:0]       rr_grant;
    logic             unused_sel;

    assign unused_sel = ^Mux_Sel;
    assign rr_grant   = rr_next(MAX_CH'(s_tvalid), 4'(last_grant_q), N_CH);
`endif

    always_comb begin
        grant     = cur_sel_q;
        grant_vld = 1'b1;
        if (state_q == IDLE) begin
`ifdef AXIS_MUX_PKT_RR_ARB_EN
            grant     = rr_grant[SEL_W-1:0];
            grant_vld = ~rr_grant[4];
`else
            grant     = Mux_Sel;
            grant_vld = (32'(Mux_Sel) < N_CH);
`endif
        end
    end

    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        s_tready  = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (grant_vld && grant == SEL_W'(k)) begin
                sel_data    = s_tdata[k*DATA_W +: DATA_W];
                sel_valid   = s_tvalid[k];
                sel_last    = s_tlast[k];
                s_tready[k] = slice_ready;
            end
        end
    end

    assign accept = sel_valid & slice_ready;

    always_comb begin
        state_d   = state_q;
        cur_sel_d = cur_sel_q;
`ifdef AXIS_MUX_PKT_RR_ARB_EN
        last_grant_d = last_grant_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
`ifdef AXIS_MUX_PKT_RR_ARB_EN
                    last_grant_d = grant;
`endif
                    // A single-beat packet leaves the channel lock untouched.
                    if (!sel_last) begin
                        state_d   = BUSY;
                        cur_sel_d = grant;
                    end
                end
            end
            BUSY: begin
                if (accept && sel_last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= IDLE;
            cur_sel_q <= '0;
`ifdef AXIS_MUX_PKT_RR_ARB_EN
            last_grant_q <= SEL_W'(N_CH - 1);
`endif
        end else begin
            state_q   <= state_d;
            cur_sel_q <= cur_sel_d;
`ifdef AXIS_MUX_PKT_RR_ARB_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    axis_skid_slice #(
        .DATA_W (DATA_W)
    ) u_slice (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .s_tdata_i  (sel_data),
        .s_tlast_i  (sel_last),
        .s_tvalid_i (sel_valid),
        .s_tready_o (slice_ready),
        .m_tdata_o  (m_tdata),
        .m_tlast_o  (m_tlast),
        .m_tvalid_o (m_tvalid),
        .m_tready_i (m_tready)
    );

    assign busy    = (state_q == BUSY);
    assign cur_sel = cur_sel_q;

endmodule

// File: tb/tb_axis_mux_pkt.sv
// Self-checking bench for axis_mux_pkt: vector table for routing plus sequences
// for packet lock, backpressure, out-of-range select, reset and (RR build) arbitration.
module tb_axis_mux_pkt;

    logic         aclk;
    logic         aresetn;
    logic [1:0]   mux_sel;
    logic [127:0] s_tdata;
    logic [3:0]   s_tvalid, s_tlast, s_tready;
    logic [31:0]  m_tdata;
    logic         m_tvalid, m_tlast, m_tready, busy;
    logic [1:0]   cur_sel;

    logic [1:0]   sel3;
    logic [95:0]  s_tdata3;
    logic [2:0]   s_tvalid3, s_tlast3, s_tready3;
    logic [31:0]  m_tdata3;
    logic         m_tvalid3, m_tlast3, m_tready3, busy3;
    logic [1:0]   cur_sel3;

    axis_mux_pkt #(.N_CH(4), .DATA_W(32)) u_dut (
        .aclk(aclk), .aresetn(aresetn), .Mux_Sel(mux_sel),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
        .busy(busy), .cur_sel(cur_sel)
    );

    axis_mux_pkt #(.N_CH(3), .DATA_W(32)) u_dut3 (
        .aclk(aclk), .aresetn(aresetn), .Mux_Sel(sel3),
        .s_tdata(s_tdata3), .s_tvalid(s_tvalid3), .s_tlast(s_tlast3), .s_tready(s_tready3),
        .m_tdata(m_tdata3), .m_tvalid(m_tvalid3), .m_tlast(m_tlast3), .m_tready(m_tready3),
        .busy(busy3), .cur_sel(cur_sel3)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct {
        logic [1:0]  sel;
        logic [3:0]  vld;
        logic [3:0]  last;
        logic [31:0] dat;
        logic        rdy;
        logic [3:0]  e_srdy;
        logic        e_mv;
        logic [31:0] e_md;
        logic        e_ml;
        logic        e_busy;
    } vec_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          ch_beat[4];
    int          ch_len[4];
    int          ch_pkt[4];
    logic [32:0] out_q[$];
    logic [32:0] exp_q[$];
    logic        busy_s;
    int          occ, rdy_bad, mv_bad, stable_bad, busy_bad, b;
    bit          bp_mode, hold_pend;
    logic [32:0] hold_val;
    logic [3:0]  pat;
    vec_t        vecs[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] word(input int k, input int beat);
        return (32'(k) << 28) | 32'(beat);
    endfunction

    task automatic setup_pkts(input int l0, input int l1, input int l2, input int l3);
        ch_len[0] = l0; ch_len[1] = l1; ch_len[2] = l2; ch_len[3] = l3;
        for (int k = 0; k < 4; k++) begin
            ch_beat[k] = 0;
            ch_pkt[k]  = (ch_len[k] > 0) ? ch_len[k] : 1;
        end
        out_q.delete();
        exp_q.delete();
        hold_pend = 1'b0;
    endtask

    task automatic push_exp(input int k, input int b0, input int n, input int pkt);
        for (int i = b0; i < b0 + n; i++)
            exp_q.push_back({1'((i % pkt) == pkt - 1), word(k, i)});
    endtask

    task automatic set_inputs();
        for (int k = 0; k < 4; k++) begin
            s_tvalid[k]          = (ch_beat[k] < ch_len[k]);
            s_tlast[k]           = s_tvalid[k] && ((ch_beat[k] % ch_pkt[k]) == ch_pkt[k] - 1);
            s_tdata[k*32 +: 32]  = word(k, ch_beat[k]);
        end
    endtask

    // One clock of packet traffic: drive, sample 1 ns later, advance on accepted beats.
    task automatic drive_cycle();
        logic [3:0] acc;
        int         pop;
        set_inputs();
        #1;
        busy_s = busy;
        if (hold_pend && (!m_tvalid || {m_tlast, m_tdata} != hold_val)) stable_bad++;
        hold_pend = m_tvalid && !m_tready;
        hold_val  = {m_tlast, m_tdata};
        pop = (m_tvalid && m_tready) ? 1 : 0;
        if (pop == 1) out_q.push_back({m_tlast, m_tdata});
        acc = s_tvalid & s_tready;
        if (bp_mode) begin
            if (s_tready[0] != (occ < 2)) rdy_bad++;
            if (m_tvalid != (occ > 0)) mv_bad++;
            occ = occ + (acc[0] ? 1 : 0) - pop;
        end
        @(negedge aclk);
        for (int k = 0; k < 4; k++) if (acc[k]) ch_beat[k]++;
    endtask

    task automatic compare_q(input string name);
        int bad;
        bad = 0;
        check({name, "_len"}, 64'(out_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < out_q.size() && i < exp_q.size(); i++)
            if (out_q[i] !== exp_q[i]) bad++;
        check({name, "_data"}, 64'(bad), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        aresetn = 1'b0; mux_sel = '0; s_tdata = '0; s_tvalid = '0; s_tlast = '0; m_tready = 1'b0;
        sel3 = '0; s_tdata3 = '0; s_tvalid3 = '0; s_tlast3 = '0; m_tready3 = 1'b1;
        bp_mode = 1'b0; occ = 0; rdy_bad = 0; mv_bad = 0; stable_bad = 0; hold_pend = 1'b0;
        for (int k = 0; k < 4; k++) begin ch_beat[k] = 0; ch_len[k] = 0; ch_pkt[k] = 1; end

        repeat (2) @(negedge aclk);
        check("rst_m_tvalid", 64'(m_tvalid), 64'(0));
        check("rst_m_tdata",  64'(m_tdata),  64'(0));
        check("rst_m_tlast",  64'(m_tlast),  64'(0));
        check("rst_s_tready", 64'(s_tready), 64'(0));
        check("rst_busy",     64'(busy),     64'(0));
        check("rst_cur_sel",  64'(cur_sel),  64'(0));
        aresetn = 1'b1;
        @(negedge aclk);

`ifdef AXIS_MUX_PKT_RR_ARB_EN
        // Channels 0, 1, 3 hold 2-beat packets (ch0 two of them); Mux_Sel points at idle ch2.
        setup_pkts(4, 2, 0, 2);
        for (int k = 0; k < 4; k++) ch_pkt[k] = 2;
        mux_sel = 2'd2; m_tready = 1'b1;
        for (int c = 0; c < 60 && out_q.size() < 8; c++) drive_cycle();
        push_exp(0, 0, 2, 2); push_exp(1, 0, 2, 2); push_exp(3, 0, 2, 2); push_exp(0, 2, 2, 2);
        compare_q("rr_order");
`else
        // {sel, vld, last, dat, m_tready | s_tready, m_tvalid, m_tdata, m_tlast, busy}
        vecs[0] = '{2'd2, 4'b0100, 4'b0000, 32'hA0, 1'b1, 4'b0100, 1'b0, 32'h0,        1'b0, 1'b0};
        vecs[1] = '{2'd2, 4'b0110, 4'b0000, 32'hA1, 1'b1, 4'b0100, 1'b1, 32'h2000_00A0, 1'b0, 1'b1};
        vecs[2] = '{2'd1, 4'b0110, 4'b0100, 32'hA2, 1'b1, 4'b0100, 1'b1, 32'h2000_00A1, 1'b0, 1'b1};
        vecs[3] = '{2'd1, 4'b0000, 4'b0000, 32'h00, 1'b1, 4'b0010, 1'b1, 32'h2000_00A2, 1'b1, 1'b0};
        vecs[4] = '{2'd0, 4'b0001, 4'b0001, 32'hB0, 1'b1, 4'b0001, 1'b0, 32'h0,        1'b0, 1'b0};
        vecs[5] = '{2'd0, 4'b0000, 4'b0000, 32'h00, 1'b1, 4'b0001, 1'b1, 32'h0000_00B0, 1'b1, 1'b0};
        vecs[6] = '{2'd1, 4'b0000, 4'b0000, 32'h00, 1'b1, 4'b0010, 1'b0, 32'h0,        1'b0, 1'b0};
        for (int i = 0; i < 7; i++) begin
            mux_sel = vecs[i].sel; s_tvalid = vecs[i].vld; s_tlast = vecs[i].last;
            m_tready = vecs[i].rdy;
            for (int k = 0; k < 4; k++) s_tdata[k*32 +: 32] = word(k, int'(vecs[i].dat));
            #1;
            check($sformatf("vec%0d_s_tready", i), 64'(s_tready), 64'(vecs[i].e_srdy));
            check($sformatf("vec%0d_m_tvalid", i), 64'(m_tvalid), 64'(vecs[i].e_mv));
            check($sformatf("vec%0d_busy", i),     64'(busy),     64'(vecs[i].e_busy));
            if (vecs[i].e_mv) begin
                check($sformatf("vec%0d_m_tdata", i), 64'(m_tdata), 64'(vecs[i].e_md));
                check($sformatf("vec%0d_m_tlast", i), 64'(m_tlast), 64'(vecs[i].e_ml));
            end
            @(negedge aclk);
        end

        // Packet lock: Mux_Sel moves 1 -> 3 after two ch1 beats; ch3 waits for ch1 tlast.
        setup_pkts(0, 8, 0, 2);
        mux_sel = 2'd1; m_tready = 1'b1; busy_bad = 0;
        for (int c = 0; c < 60 && out_q.size() < 10; c++) begin
            b = ch_beat[1];
            if (b >= 2) mux_sel = 2'd3;
            drive_cycle();
            if (b < 8 && busy_s != (b >= 1)) busy_bad++;
        end
        push_exp(1, 0, 8, 8); push_exp(3, 0, 2, 2);
        compare_q("lock_order");
        check("lock_busy", 64'(busy_bad), 64'(0));
        check("lock_cur_sel", 64'(cur_sel), 64'(3));

        // Backpressure: m_tready cycles 1,0,0,1 against a continuous 12-beat ch0 stream.
        setup_pkts(12, 0, 0, 0);
        mux_sel = 2'd0; occ = 0; rdy_bad = 0; mv_bad = 0; stable_bad = 0; bp_mode = 1'b1;
        pat = 4'b1001;
        for (int c = 0; c < 100 && out_q.size() < 12; c++) begin
            m_tready = pat[c % 4];
            drive_cycle();
        end
        bp_mode = 1'b0; m_tready = 1'b1;
        push_exp(0, 0, 12, 12);
        compare_q("bp_stream");
        check("bp_s_tready", 64'(rdy_bad), 64'(0));
        check("bp_m_tvalid", 64'(mv_bad), 64'(0));
        check("bp_stable", 64'(stable_bad), 64'(0));

        // Out-of-range select on a 3-channel instance.
        sel3 = 2'd3; s_tvalid3 = 3'b111; s_tlast3 = 3'b111; s_tdata3 = {3{32'h5A5A_0001}};
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("oor%0d_s_tready", c), 64'(s_tready3), 64'(0));
            check($sformatf("oor%0d_m_tvalid", c), 64'(m_tvalid3), 64'(0));
            @(negedge aclk);
        end
        sel3 = 2'd2;
        #1;
        check("oor_valid_sel", 64'(s_tready3), 64'(3'b100));
        @(negedge aclk);
        s_tvalid3 = '0;

        // Reset while beat 4 of a 6-beat packet is presented.
        setup_pkts(6, 0, 0, 0);
        mux_sel = 2'd0; m_tready = 1'b1;
        for (int c = 0; c < 20 && ch_beat[0] < 3; c++) drive_cycle();
        set_inputs();
        #2;
        check("rst_mid_pre_busy", 64'(busy), 64'(1));
        check("rst_mid_pre_mv", 64'(m_tvalid), 64'(1));
        aresetn = 1'b0;
        #1;
        check("rst_mid_m_tvalid", 64'(m_tvalid), 64'(0));
        check("rst_mid_busy",     64'(busy),     64'(0));
        check("rst_mid_s_tready", 64'(s_tready), 64'(0));
        check("rst_mid_m_tdata",  64'(m_tdata),  64'(0));
        @(negedge aclk);
        aresetn = 1'b1;
        setup_pkts(0, 0, 3, 0);
        mux_sel = 2'd2;
        for (int c = 0; c < 30 && out_q.size() < 3; c++) drive_cycle();
        push_exp(2, 0, 3, 3);
        compare_q("rst_recover");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
